// File: rtl/pll_rstseq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
// Defaults assume a 360 MHz reference clock.
package pll_rstseq_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 360;     // 1 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 360000;  // 1 ms
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 3600;    // 10 us
  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_CNT_W               = 20;
  localparam int unsigned DEF_RETRY_W             = 8;

  // Reset-control outputs as a group; each is a pure decode of the state.
  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c.pll_rst = (s == RESET_PLL);
    c.sys_rst = (s != RUN);
    c.ready   = (s == RUN);
    return c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and system-side signals of the reset sequencer.
//   pll_rst     : reset to the PLL
//   pll_locked  : PLL lock indicator (asynchronous)
//   sys_rst     : downstream system reset
//   ready       : system out of reset (== ~sys_rst)
//   timeout_err : sticky lock-timeout flag
//   retry_count : saturating count of PLL re-resets
// master = the sequencer, slave = the PLL/system side.
interface pll_reset_sequencer_if #(
  parameter int unsigned RETRY_W = 8
);
  logic               pll_rst;
  logic               pll_locked;
  logic               sys_rst;
  logic               ready;
  logic               timeout_err;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    output pll_rst, sys_rst, ready, timeout_err, retry_count,
    input  pll_locked
  );

  modport slave (
    input  pll_rst, sys_rst, ready, timeout_err, retry_count,
    output pll_locked
  );
endinterface

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser for the asynchronous PLL lock signal.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears the chain to 0
//   d   : asynchronous input
//   q   : synchronised output, SYNC_STAGES cycles after d
module pll_lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits (with timeout) for lock,
// debounces lock, then releases the system reset. Lock loss or timeout
// re-issues the PLL reset and bumps a saturating retry counter.
//   refclk : PLL reference clock
//   rst    : synchronous active-high reset
//   bus    : master side of pll_reset_sequencer_if
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W               = DEF_CNT_W,
  parameter int unsigned RETRY_W             = DEF_RETRY_W
) (
  input logic                    refclk,
  input logic                    rst,
  pll_reset_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic               lk;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               to_q, to_d;
  ctrl_t              ctrl_q;

  // Lock synchroniser.
  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (bus.pll_locked),
    .q  (lk)
  );

  // State, counter and status registers; control outputs are registered
  // from the next state so they track the state register exactly.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
      to_q    <= 1'b0;
      ctrl_q  <= ctrl_for(RESET_PLL);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  // Next-state, phase counter and status updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    to_d    = to_q;

    unique case (state_q)
      RESET_PLL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Lock seen on the final budget cycle still counts as lock.
        if (lk) begin
          state_d = STABILIZE;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESET_PLL;
          to_d    = 1'b1;
          retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
        end
      end
      STABILIZE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lk)                     state_d = WAIT_LOCK;
        else if (cnt_q == STAB_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lk) begin
          state_d = RESET_PLL;
          retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
        end
      end
      default: state_d = RESET_PLL;
    endcase

    // Every state entry starts a fresh phase count.
    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.pll_rst     = ctrl_q.pll_rst;
  assign bus.sys_rst     = ctrl_q.sys_rst;
  assign bus.ready       = ctrl_q.ready;
  assign bus.timeout_err = to_q;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters
// (reset 4, timeout 20, stable 8, 2 sync stages).
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer_if #(.RETRY_W(8)) bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .SYNC_STAGES        (2),
    .CNT_W              (20),
    .RETRY_W            (8)
  ) dut (
    .refclk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int n;       // cycles this row is applied
    bit rst;
    bit lock;
    bit prst;    // expected outputs after each edge
    bit srst;
    bit rdy;
    bit to;
    int rc;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tick until pll_rst equals v (bounded); returns cycles taken.
  task automatic wait_prst(input bit v, input int max, output int n);
    n = 0;
    while (bus.pll_rst != v && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_rc;
    bus.pll_locked = 1'b0;

    // Reset, clean lock, lock loss in RUN and relock.
    tbl.push_back('{3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst = tbl[i].rst;
        bus.pll_locked = tbl[i].lock;
        tick();
        chk($sformatf("tbl%0d.%0d pll_rst", i, k), int'(bus.pll_rst), int'(tbl[i].prst));
        chk($sformatf("tbl%0d.%0d sys_rst", i, k), int'(bus.sys_rst), int'(tbl[i].srst));
        chk($sformatf("tbl%0d.%0d ready", i, k), int'(bus.ready), int'(tbl[i].rdy));
        chk($sformatf("tbl%0d.%0d timeout_err", i, k), int'(bus.timeout_err), int'(tbl[i].to));
        chk($sformatf("tbl%0d.%0d retry_count", i, k), int'(bus.retry_count), tbl[i].rc);
      end
    end

    // Lock glitch in STABILIZE, landing on its final cycle.
    do_reset();
    wait_prst(1'b0, 10, n);
    chk("glitch rst_len", n, 4);
    for (int k = 1; k <= 22; k++) begin
      bus.pll_locked = !(k >= 9 && k <= 11);
      tick();
      chk($sformatf("glitch%0d pll_rst", k), int'(bus.pll_rst), 0);
      chk($sformatf("glitch%0d ready", k), int'(bus.ready), (k == 22) ? 1 : 0);
    end
    chk("glitch retry_count", int'(bus.retry_count), 0);
    chk("glitch timeout_err", int'(bus.timeout_err), 0);

    // Reset mid-STABILIZE after two timeouts.
    do_reset();
    wait_prst(1'b0, 10, n);
    chk("midrst rst_len0", n, 4);
    for (int t = 1; t <= 2; t++) begin
      wait_prst(1'b1, 40, n);
      chk($sformatf("midrst wait%0d", t), n, 20);
      chk($sformatf("midrst rc%0d", t), int'(bus.retry_count), t);
      chk($sformatf("midrst to%0d", t), int'(bus.timeout_err), 1);
      wait_prst(1'b0, 10, n);
      chk($sformatf("midrst rst_len%0d", t), n, 4);
    end
    for (int k = 1; k <= 6; k++) begin
      bus.pll_locked = 1'b1;
      tick();
    end
    chk("midrst pre sys_rst", int'(bus.sys_rst), 1);
    rst = 1'b1;
    tick();
    chk("midrst pll_rst", int'(bus.pll_rst), 1);
    chk("midrst sys_rst", int'(bus.sys_rst), 1);
    chk("midrst ready", int'(bus.ready), 0);
    chk("midrst timeout_err", int'(bus.timeout_err), 0);
    chk("midrst retry_count", int'(bus.retry_count), 0);
    rst = 1'b0;
    wait_prst(1'b0, 10, n);
    chk("midrst restart rst_len", n, 4);
    n = 0;
    while (!bus.ready && n < 40) begin
      tick();
      n++;
    end
    chk("midrst relock cycles", n, 9);
    chk("midrst relock rc", int'(bus.retry_count), 0);

    // 300 consecutive timeouts: retry_count saturates at 255.
    do_reset();
    wait_prst(1'b0, 10, n);
    chk("sat rst_len", n, 4);
    for (int i = 1; i <= 300; i++) begin
      wait_prst(1'b1, 40, n);
      chk($sformatf("sat%0d wait", i), n, 20);
      exp_rc = (i > 255) ? 255 : i;
      chk($sformatf("sat%0d retry_count", i), int'(bus.retry_count), exp_rc);
      chk($sformatf("sat%0d timeout_err", i), int'(bus.timeout_err), 1);
      wait_prst(1'b0, 10, n);
      chk($sformatf("sat%0d rst_len", i), n, 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Drives the reset input of a clock-generation PLL and consumes its `locked` output, i.e. the other end of the PLL rst/locked interface.
- Pulses the PLL reset at start-up and waits for lock, with a timeout.
- Debounces lock, then releases the downstream system reset.
- On lock loss or lock timeout it re-issues the PLL reset and counts retries.
- Runs on the PLL reference clock, so it is live before any PLL output exists.

Parameters:
- PLL_RST_CYCLES, 360: cycles `pll_rst` is held high per reset pulse (1 us at 360 MHz); minimum 1.
- LOCK_TIMEOUT_CYCLES, 360000: maximum cycles to wait for lock after `pll_rst` falls (1 ms); minimum 1.
- LOCK_STABLE_CYCLES, 3600: cycles `locked` must stay continuously high before `sys_rst` is released; minimum 1.
- SYNC_STAGES, 2: flip-flop stages synchronising the asynchronous `pll_locked` input; minimum 2.
- CNT_W, 20: phase counter width; must hold max(all cycle parameters) - 1.
- RETRY_W, 8: width of the retry counter.

Ports:
- refclk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: PLL lock indicator; asynchronous to refclk.
- pll_rst, output, 1: reset to PLL; high only in state RESET_PLL.
- sys_rst, output, 1: downstream reset; low only in state RUN.
- ready, output, 1: high only in state RUN; equals ~sys_rst.
- timeout_err, output, 1: sticky flag; set on any lock timeout.
- retry_count, output, RETRY_W: number of PLL re-resets; saturating.

Behaviour:
- Reset values, while rst=1: state=RESET_PLL, cnt=0, pll_rst=1, sys_rst=1, ready=0, timeout_err=0, retry_count=0, sync chain=0.
- All outputs are registered; each is a pure function of the current state register and the sticky/counter registers.
- `lk` is pll_locked after SYNC_STAGES flops. Input-to-lk latency is SYNC_STAGES cycles.
- cnt clears to 0 on every state entry and increments each cycle in a counting state. "cnt==N-1" means the state has occupied exactly N cycles.
- RESET_PLL: pll_rst=1.
  - When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - lk is ignored in this state.
  - The first cycle after rst falls is cycle 0 of RESET_PLL.
- WAIT_LOCK: pll_rst=0.
  - If lk=1, go to STABILIZE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: go to RESET_PLL, set timeout_err, retry_count+1.
  - If both conditions hold in the same cycle, lk wins.
- STABILIZE:
  - If lk=0, go to WAIT_LOCK. cnt restarts and the full timeout budget applies; no PLL reset is issued.
  - Else if cnt==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN: sys_rst=0, ready=1.
  - If lk=0: go to RESET_PLL, retry_count+1; timeout_err is unchanged.
  - sys_rst reasserts in the cycle RESET_PLL is entered.
- retry_count saturates at all-ones and never wraps.
- timeout_err is cleared only by rst.
- rst asserted in any state forces reset values on the next edge, regardless of lk or cnt.
- Illegal state encodings go to RESET_PLL.
- A lk glitch shorter than one cycle is not required to be seen. Any lk=0 sample is acted on as specified above.

Decomposition:
- Shared include/package `pll_rstseq_pkg` holds:
  - the state localparams (RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3; 2-bit encoding);
  - the default cycle constants for a 360 MHz refclk.
- One sub-module, `pll_lock_sync`: a parameterised SYNC_STAGES flip-flop synchroniser with synchronous reset to 0 and async-register attributes.
- The FSM, counter and status registers stay in the top module.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2):
- Reset: hold rst=1 for 3 cycles, then 0, pll_locked=0 -> during rst, pll_rst=1, sys_rst=1, ready=0, retry_count=0. After release, pll_rst stays high exactly 4 cycles then falls.
- Clean lock: pll_locked rises 5 cycles after pll_rst falls and stays high -> STABILIZE is entered 2 cycles later. sys_rst falls and ready rises 8 cycles after that. timeout_err=0, retry_count=0.
- Timeout: pll_locked held at 0 -> pll_rst re-asserts 20 cycles after falling, for 4 cycles; retry_count=1, timeout_err=1. Run 300 timeouts -> retry_count=255 and holds.
- Stabilize glitch: drop pll_locked for 3 cycles at STABILIZE cnt=5 -> returns to WAIT_LOCK with pll_rst still 0. After relock, a full 8 stable cycles are required before ready=1.
- Lock loss in RUN: drop pll_locked -> sys_rst=1 and ready=0 within 3 cycles; pll_rst high 4 cycles; retry_count increments; timeout_err unchanged; normal relock follows.
- Reset mid-operation: assert rst at STABILIZE cnt=3 with retry_count=2 and timeout_err=1 -> next edge gives all outputs at reset values (retry_count=0, timeout_err=0). Sequence restarts from RESET_PLL.
